// File: rtl/tdm_demux_pkg.sv
// Shared constants and FSM state type for the 1-to-8 TDM demultiplexer.
package tdm_demux_pkg;

    localparam int unsigned NUM_SLOTS = 8;
    localparam int unsigned SEL_W     = 3;

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

endpackage

// File: rtl/tdm_demultiplexer_1_8_demux.sv
// Combinational 1-to-8 write-enable decoder; logical inverse of the 8:1 channel mux.
module demultiplexer_1_8
    import tdm_demux_pkg::*;
(
    input  logic                 en,
    input  logic [SEL_W-1:0]     sel,
    output logic [NUM_SLOTS-1:0] we
);

    always_comb begin
        we = '0;
        if (en) begin
            we[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demultiplexer_1_8.sv
// Receive end of the 8:1 TDM path: collects slots 0..7 into a shadow register
// and publishes the complete frame as one registered word with a one-cycle strobe.
module tdm_demultiplexer_1_8
    import tdm_demux_pkg::*;
#(
    parameter int unsigned DATA_W = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           din,
    input  logic                        din_valid,
    input  logic                        sof,
    output logic [NUM_SLOTS*DATA_W-1:0] y,
    output logic                        frame_valid,
    output logic [SEL_W-1:0]            sel,
    output logic                        frame_err
);

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NUM_SLOTS - 1);

    state_t                             state, state_nxt;
    logic   [SEL_W-1:0]                 sel_nxt;
    logic                               fv_nxt, fe_nxt;
    logic                               wr_en, publish;
    logic   [SEL_W-1:0]                 wr_sel;
    logic   [NUM_SLOTS-1:0]             we;
    logic   [NUM_SLOTS-1:0][DATA_W-1:0] shadow;

    demultiplexer_1_8 u_decode (
        .en  (wr_en),
        .sel (wr_sel),
        .we  (we)
    );

    // An sof always restarts at slot 0, whether idle or mid-frame.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        fv_nxt    = 1'b0;
        fe_nxt    = 1'b0;
        wr_en     = 1'b0;
        wr_sel    = sel;
        publish   = 1'b0;
        if (din_valid) begin
            if (sof) begin
                wr_en     = 1'b1;
                wr_sel    = '0;
                sel_nxt   = SEL_W'(1);
                state_nxt = COLLECT;
                fe_nxt    = (state == COLLECT);
            end else if (state == COLLECT) begin
                wr_en   = 1'b1;
                sel_nxt = sel + SEL_W'(1);
                if (sel == LAST_SLOT) begin
                    publish   = 1'b1;
                    fv_nxt    = 1'b1;
                    state_nxt = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sel         <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            sel         <= sel_nxt;
            frame_valid <= fv_nxt;
            frame_err   <= fe_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
                if (we[k]) begin
                    shadow[k] <= din;
                end
            end
        end
    end

    // Slot 7 goes straight from din so the word is complete on the accepting edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y <= '0;
        end else if (publish) begin
            y <= {din, shadow[NUM_SLOTS-2:0]};
        end
    end

endmodule

// File: tb/tb_tdm_demultiplexer_1_8.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based frame model.
module tb_tdm_demultiplexer_1_8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [0:0] din = '0;
    logic       din_valid = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] y;
    logic       frame_valid;
    logic [2:0] sel;
    logic       frame_err;

    int compared = 0;
    int mismatched = 0;

    // Reference model: samples of the frame in progress, published when eight are held.
    int         m_q[$];
    bit         m_in = 1'b0;
    logic [7:0] m_y = '0;
    bit         m_fv = 1'b0;
    bit         m_fe = 1'b0;

    tdm_demultiplexer_1_8 #(.DATA_W(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .sof         (sof),
        .y           (y),
        .frame_valid (frame_valid),
        .sel         (sel),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_in = 1'b0;
        m_y  = '0;
        m_fv = 1'b0;
        m_fe = 1'b0;
    endtask

    task automatic model_step(input bit v, input bit s, input bit d);
        m_fv = 1'b0;
        m_fe = 1'b0;
        if (v) begin
            if (s) begin
                if (m_in) m_fe = 1'b1;
                m_q.delete();
                m_q.push_back(int'(d));
                m_in = 1'b1;
            end else if (m_in) begin
                m_q.push_back(int'(d));
                if (m_q.size() == 8) begin
                    for (int k = 0; k < 8; k++) m_y[k] = m_q[k][0];
                    m_fv = 1'b1;
                    m_in = 1'b0;
                    m_q.delete();
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".y"}, 32'(y), 32'(m_y));
        chk({tag, ".frame_valid"}, 32'(frame_valid), 32'(m_fv));
        chk({tag, ".frame_err"}, 32'(frame_err), 32'(m_fe));
        chk({tag, ".sel"}, 32'(sel), m_in ? 32'(m_q.size()) : 32'd0);
    endtask

    task automatic cycle(input bit v, input bit s, input bit d, input string tag);
        din_valid = v;
        sof       = s;
        din       = d;
        @(posedge clk);
        model_step(v, s, d);
        #1;
        check_all(tag);
    endtask

    task automatic send_slots(input logic [7:0] val, input int first, input int last,
                              input int gap_after, input int gap_len, input string tag);
        for (int k = first; k <= last; k++) begin
            cycle(1'b1, k == 0, val[k], tag);
            if (k == gap_after) begin
                for (int g = 0; g < gap_len; g++) cycle(1'b0, 1'b0, 1'b0, {tag, ".gap"});
            end
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        rst = 1'b0;
    endtask

    initial begin
        din_valid = 1'b0;
        sof = 1'b0;
        din = '0;
        #2;
        do_reset("reset");
        cycle(1'b0, 1'b0, 1'b0, "idle");

        // Basic frame, LSB-first slots 1,0,1,1,0,0,1,0.
        send_slots(8'b01001101, 0, 7, -1, 0, "frame1");
        chk("frame1.const_y", 32'(y), 32'h4D);
        chk("frame1.const_fv", 32'(frame_valid), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, "frame1.after");

        // Same frame with a 3-cycle valid gap between slots 3 and 4.
        send_slots(8'b01001101, 0, 7, 3, 3, "gap");
        chk("gap.const_y", 32'(y), 32'h4D);

        // Back-to-back frames.
        send_slots(8'hA5, 0, 7, -1, 0, "b2b_a5");
        chk("b2b.const_a5", 32'(y), 32'hA5);
        send_slots(8'h3C, 0, 7, -1, 0, "b2b_3c");
        chk("b2b.const_3c", 32'(y), 32'h3C);

        // Abort at slot 5, then full frame FF.
        send_slots(8'h00, 0, 4, -1, 0, "abort_part");
        cycle(1'b1, 1'b1, 1'b1, "abort_sof");
        chk("abort.const_err", 32'(frame_err), 32'd1);
        chk("abort.const_yhold", 32'(y), 32'h3C);
        send_slots(8'hFF, 1, 7, -1, 0, "abort_ff");
        chk("abort.const_ff", 32'(y), 32'hFF);

        // Idle samples without sof are ignored.
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, k[0], "idle_nosof");
        chk("idle.const_sel", 32'(sel), 32'd0);

        // Reset at slot 6, then a clean frame.
        send_slots(8'h5A, 0, 5, -1, 0, "rst_part");
        #2;
        do_reset("rst_mid");
        chk("rst_mid.const_y", 32'(y), 32'd0);
        send_slots(8'hC3, 0, 7, -1, 0, "post_rst");
        chk("post_rst.const_y", 32'(y), 32'hC3);

        // Sof at slot 7 aborts even a nearly complete frame.
        send_slots(8'h00, 0, 6, -1, 0, "late_part");
        cycle(1'b1, 1'b1, 1'b0, "late_sof");
        send_slots(8'h81, 1, 7, -1, 0, "late_full");

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                  1'($urandom), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
